// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver with pin sync, clock glitch filter,
// odd-parity/stop checking and mid-frame stall recovery.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       ps2_int,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic [1:0]            clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d, fclk_prev_q, fclk_prev_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d, scan_q, scan_d;
    logic                  par_q, par_d, int_q, int_d;
    logic                  errp_q, errp_d, errf_q, errf_d, errt_q, errt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  fall, sample, timeout;
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        filt_d      = {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
        fclk_d      = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fclk_q;
        fclk_prev_d = fclk_q;
        fall        = fclk_prev_q & ~fclk_q;
        sample      = dat_sync_q[1];
        // A fall in the same cycle as the deadline wins over the timeout
        timeout     = state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1) && !fall;
        tmo_d       = (fall || state_q == IDLE || timeout) ? '0 : tmo_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        scan_d      = scan_q;
        int_d       = 1'b0;
        errp_d      = 1'b0;
        errf_d      = 1'b0;
        errt_d      = 1'b0;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = sample ? IDLE : DATA;
                    cnt_d   = 3'd0;
                end
                DATA: begin
                    shift_d = {sample, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = cnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = sample;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    errf_d  = !sample;
                    errp_d  = sample && !(^{shift_q, par_q});
                    int_d   = sample && (^{shift_q, par_q});
                    scan_d  = int_d ? shift_q : scan_q;
                end
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            errt_d  = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            scan_q      <= '0;
            int_q       <= 1'b0;
            errp_q      <= 1'b0;
            errf_q      <= 1'b0;
            errt_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            scan_q      <= scan_d;
            int_q       <= int_d;
            errp_q      <= errp_d;
            errf_q      <= errf_d;
            errt_q      <= errt_d;
            tmo_q       <= tmo_d;
        end
    end
    assign scan_code   = scan_q;
    assign ps2_int     = int_q;
    assign err_parity  = errp_q;
    assign err_frame   = errf_q;
    assign err_timeout = errt_q;
    assign busy        = state_q != IDLE;
endmodule
